t_ram_dp: RTL and testbench

T_RAM_DP -- requirements
Module: t_ram_dp

---
 rtl/t_ram_pkg.sv | 18 +
 rtl/t_ram_dp_if.sv | 29 ++
 rtl/t_ram_be_merge.sv | 24 ++
 rtl/t_ram_dp.sv | 128 ++++++++++++
 tb/tb_t_ram_dp.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/t_ram_pkg.sv
// Shared definitions for the t_ram dual-port RAM family.
//   ram_state_t : controller states (INIT clear sweep, RUN normal access)
//   RD_LAT_*    : legal read-latency settings
//   FWD_*       : collision behaviour settings (old data vs forwarded write data)
package t_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ram_state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  localparam int FWD_OLD = 0;
  localparam int FWD_NEW = 1;

endpackage

// File: rtl/t_ram_dp_if.sv
// Access bus of the dual-port RAM: one write port, one read port and status.
//   master : drives write/read requests, receives read data, valid and busy
//   slave  : the RAM side
interface t_ram_dp_if #(
  parameter int DW = 16,
  parameter int AW = 4
) ();

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_din;
  logic [DW/8-1:0] wr_be;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_dout;
  logic            rd_valid;
  logic            init_busy;

  modport master (
    output wr_en, wr_addr, wr_din, wr_be, rd_en, rd_addr,
    input  rd_dout, rd_valid, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_din, wr_be, rd_en, rd_addr,
    output rd_dout, rd_valid, init_busy
  );

endinterface

// File: rtl/t_ram_be_merge.sv
// Byte-enable merge: replaces the enabled bytes of old_word with new_word.
//   old_word : word currently stored
//   new_word : incoming write data
//   be       : byte enables, bit i selects bits [8i+7:8i]
//   merged   : resulting word
module t_ram_be_merge #(
  parameter int DW = 16
) (
  input  logic [DW-1:0]   old_word,
  input  logic [DW-1:0]   new_word,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   merged
);

  always_comb begin
    // NOTE: assigning the default before the loop keeps every bit driven on
    // every path, so no latch is inferred for disabled bytes.
    merged = old_word;
    for (int i = 0; i < DW / 8; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/t_ram_dp.sv
// Simple dual-port RAM with byte-enabled writes, a post-reset clear sweep,
// selectable read latency (1 or 2) and optional write-to-read forwarding.
//   clk     : single clock, rising edge
//   sys_rst : synchronous active-high reset, highest priority
//   bus     : t_ram_dp_if slave port (write/read requests, rd_dout,
//             rd_valid, init_busy)
module t_ram_dp
  import t_ram_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 4,
  parameter int RD_LAT = 1,
  parameter int FWD    = 1
) (
  input logic        clk,
  input logic        sys_rst,
  t_ram_dp_if.slave  bus
);

  localparam int DEPTH  = 2 ** AW;
  localparam bit FWD_ON = (FWD == FWD_NEW);

  ram_state_t    state;
  ram_state_t    state_nxt;
  logic [AW-1:0] clr_cnt;
  logic          wr_go;
  logic          rd_go;

  // ---------------------------------------------------------------------
  // Controller: INIT clears one word per cycle, then RUN serves requests.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (sys_rst) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    case (state)
      ST_INIT: begin
        // Last word of the sweep is written this cycle.
        if (clr_cnt == {AW{1'b1}}) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        wr_go = bus.wr_en;
        rd_go = bus.rd_en;
      end
    endcase
  end

  assign bus.init_busy = (state == ST_INIT);

  // ---------------------------------------------------------------------
  // Storage and write path
  // ---------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wr_word;

  // The merged word doubles as the forwarded read word on a collision,
  // because the old word at wr_addr is then the old word at rd_addr.
  t_ram_be_merge #(.DW(DW)) u_merge (
    .old_word (mem[bus.wr_addr]),
    .new_word (bus.wr_din),
    .be       (bus.wr_be),
    .merged   (wr_word)
  );

  // NOTE: the array itself is never reset; the INIT sweep zeroes it, which
  // keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      if (state == ST_INIT)  mem[clr_cnt]     <= '0;
      else if (wr_go)        mem[bus.wr_addr] <= wr_word;
    end
  end

  // ---------------------------------------------------------------------
  // Read path: first register stage always present.
  // ---------------------------------------------------------------------
  logic          collide;
  logic [DW-1:0] rd_word;
  logic          s1_valid;
  logic [DW-1:0] s1_data;

  assign collide = wr_go && rd_go && (bus.wr_addr == bus.rd_addr);
  assign rd_word = (FWD_ON && collide) ? wr_word : mem[bus.rd_addr];

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_go;
      if (rd_go) s1_data <= rd_word;   // hold last value otherwise
    end
  end

  if (RD_LAT == RD_LAT_MAX) begin : g_lat2
    logic          s2_valid;
    logic [DW-1:0] s2_data;

    always_ff @(posedge clk) begin
      if (sys_rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign bus.rd_valid = s2_valid;
    assign bus.rd_dout  = s2_data;
  end else begin : g_lat1
    assign bus.rd_valid = s1_valid;
    assign bus.rd_dout  = s1_data;
  end

endmodule

// File: tb/tb_t_ram_dp.sv
// Self-checking bench for t_ram_dp. Four instances share one stimulus:
//   cfg0 RD_LAT=1 FWD=1, cfg1 RD_LAT=1 FWD=0,
//   cfg2 RD_LAT=2 FWD=1, cfg3 RD_LAT=2 FWD=0.
// A reference model keeps a plain memory array plus a history of accepted
// reads; the compare process checks all outputs every falling edge.
`timescale 1ns/1ps
module tb_t_ram_dp;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2 ** AW;
  localparam int NCFG  = 4;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_din;
  logic [BW-1:0] wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [NCFG-1:0] valid;
  logic [NCFG-1:0] busy;
  logic [DW-1:0]   dout [NCFG];

  always #5 clk = ~clk;

  function automatic int cfg_lat(input int c);
    return (c >= 2) ? 2 : 1;
  endfunction

  function automatic bit cfg_fwd(input int c);
    return (c % 2) == 0;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    t_ram_dp_if #(.DW(DW), .AW(AW)) bus ();

    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_din  = wr_din;
    assign bus.wr_be   = wr_be;
    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = rd_addr;
    assign valid[g]    = bus.rd_valid;
    assign busy[g]     = bus.init_busy;
    assign dout[g]     = bus.rd_dout;

    t_ram_dp #(
      .DW(DW), .AW(AW),
      .RD_LAT((g >= 2) ? 2 : 1),
      .FWD((g % 2 == 0) ? 1 : 0)
    ) dut (
      .clk(clk),
      .sys_rst(sys_rst),
      .bus(bus)
    );
  end

  // ---------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  typedef struct {
    int            acc;
    logic [DW-1:0] d_fwd;
    logic [DW-1:0] d_old;
  } rd_rec_t;

  rd_rec_t         hist[$];
  logic [DW-1:0]   m_mem [DEPTH];
  int              sweep_left = 0;
  int              cyc = 0;
  bit              model_live = 0;
  logic            e_busy;
  logic [NCFG-1:0] e_valid;
  logic [DW-1:0]   e_dout [NCFG];

  always @(posedge clk) begin : p_model
    logic [DW-1:0] old_w;
    logic [DW-1:0] new_w;
    bit            hit;
    cyc++;
    if (sys_rst) begin
      model_live = 1;
      sweep_left = DEPTH;
      hist.delete();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else begin
      if (rd_en) begin
        old_w = m_mem[rd_addr];
        new_w = old_w;
        for (int b = 0; b < BW; b++) if (wr_be[b]) new_w[8*b +: 8] = wr_din[8*b +: 8];
        hit = wr_en && (wr_addr == rd_addr);
        hist.push_back('{acc: cyc, d_fwd: hit ? new_w : old_w, d_old: old_w});
      end
      if (wr_en)
        for (int b = 0; b < BW; b++) if (wr_be[b]) m_mem[wr_addr][8*b +: 8] = wr_din[8*b +: 8];
    end
    while (hist.size() > 0 && hist[0].acc < cyc - 1) void'(hist.pop_front());
    e_busy = (sweep_left > 0);
    for (int c = 0; c < NCFG; c++) begin
      e_valid[c] = 1'b0;
      if (sys_rst) e_dout[c] = '0;
      foreach (hist[i]) begin
        if (hist[i].acc == cyc - (cfg_lat(c) - 1)) begin
          e_valid[c] = 1'b1;
          e_dout[c]  = cfg_fwd(c) ? hist[i].d_fwd : hist[i].d_old;
        end
      end
    end
  end

  // Compare process: every falling edge once a reset has been seen.
  always @(negedge clk) begin
    if (model_live) begin
      for (int c = 0; c < NCFG; c++) begin
        check($sformatf("cfg%0d init_busy @%0d", c, cyc), 32'(busy[c]),  32'(e_busy));
        check($sformatf("cfg%0d rd_valid @%0d", c, cyc),  32'(valid[c]), 32'(e_valid[c]));
        check($sformatf("cfg%0d rd_dout @%0d", c, cyc),   32'(dout[c]),  32'(e_dout[c]));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (all drive on the falling edge)
  // ---------------------------------------------------------------------
  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd,
                       input logic [BW-1:0] be, input bit re, input int ra);
    @(negedge clk);
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_din  = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = AW'(ra);
  endtask

  // Waits for the single read issued by the previous drive() and checks the
  // latency and returned word on every configuration.
  task automatic expect_read(input string name, input logic [DW-1:0] x_fwd,
                             input logic [DW-1:0] x_old);
    bit seen [NCFG];
    for (int c = 0; c < NCFG; c++) seen[c] = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) idle();
      for (int c = 0; c < NCFG; c++) begin
        if (valid[c] && !seen[c]) begin
          seen[c] = 1;
          check($sformatf("%s cfg%0d latency", name, c), 32'(k), 32'(cfg_lat(c)));
          check($sformatf("%s cfg%0d data", name, c), 32'(dout[c]),
                32'(cfg_fwd(c) ? x_fwd : x_old));
        end
      end
    end
    for (int c = 0; c < NCFG; c++)
      if (!seen[c]) check($sformatf("%s cfg%0d valid seen", name, c), 32'(0), 32'(1));
  endtask

  // Called on the falling edge where sys_rst has just been released.
  task automatic run_sweep(input string name, input bit poke);
    int cnt = 0;
    int vp  = 0;
    while (busy[0] && cnt < 40) begin
      if (poke) begin
        wr_en   = 1'b1;
        wr_addr = AW'($urandom_range(0, DEPTH - 1));
        wr_din  = 16'hFFFF;
        wr_be   = '1;
        rd_en   = 1'b1;
        rd_addr = AW'($urandom_range(0, DEPTH - 1));
      end
      @(negedge clk);
      cnt++;
      vp += $countones(valid);
    end
    idle();
    check({name, " busy cycles"}, 32'(cnt), 32'(DEPTH));
    check({name, " valid pulses"}, 32'(vp), 32'(0));
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    logic [4:0]    vbits;
    logic [DW-1:0] dat [5];
    logic [DW-1:0] or_acc;
    int            vp0;
    int            vp2;

    sys_rst = 1'b1;
    wr_addr = '0;
    wr_din  = '0;
    wr_be   = '0;
    rd_addr = '0;
    idle();
    repeat (2) @(negedge clk);
    check("reset dout", 32'(dout[0]), 32'(0));
    check("reset valid", 32'(valid), 32'(0));
    check("reset busy", 32'(busy), 32'hF);
    sys_rst = 1'b0;
    // Requests during the sweep must be ignored.
    run_sweep("sweep1", 1'b1);

    // Full-throughput reads of every address; all must be zero.
    vp0    = 0;
    vp2    = 0;
    or_acc = '0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      @(negedge clk);
      vp0 += int'(valid[0]);
      vp2 += int'(valid[2]);
      if (valid[0]) or_acc |= dout[0];
      if (valid[2]) or_acc |= dout[2];
      if (i < DEPTH) begin
        rd_en   = 1'b1;
        rd_addr = AW'(i);
      end else begin
        idle();
      end
    end
    check("readall lat1 pulses", 32'(vp0), 32'(DEPTH));
    check("readall lat2 pulses", 32'(vp2), 32'(DEPTH));
    check("readall zero data", 32'(or_acc), 32'(0));

    // Byte-enable merge.
    drive(1, 3, 16'hBEEF, 2'b11, 0, 0);
    drive(1, 3, 16'h12AB, 2'b10, 0, 0);
    drive(0, 0, 16'h0000, 2'b00, 1, 3);
    expect_read("merge addr3", 16'h12EF, 16'h12EF);
    check("model mem3", 32'(m_mem[3]), 32'h12EF);

    // Collision: forwarded vs old word, then the stored result.
    drive(1, 5, 16'h1111, 2'b11, 0, 0);
    drive(1, 5, 16'hABCD, 2'b01, 1, 5);
    expect_read("collide addr5", 16'h11CD, 16'h1111);
    drive(0, 0, 16'h0000, 2'b00, 1, 5);
    expect_read("after collide addr5", 16'h11CD, 16'h11CD);

    // Read and write to different addresses in the same cycle.
    drive(1, 7, 16'h7777, 2'b11, 1, 3);
    expect_read("diff addr rd3", 16'h12EF, 16'h12EF);
    drive(0, 0, 16'h0000, 2'b00, 1, 7);
    expect_read("diff addr rd7", 16'h7777, 16'h7777);

    // Three back-to-back reads on the two-stage configuration.
    drive(1, 0, 16'hA000, 2'b11, 0, 0);
    drive(1, 1, 16'hA001, 2'b11, 0, 0);
    drive(1, 2, 16'hA002, 2'b11, 0, 0);
    drive(0, 0, 16'h0000, 2'b00, 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vbits[k] = valid[2];
      dat[k]   = dout[2];
      if (k < 2) rd_addr = AW'(k + 1);
      else idle();
    end
    check("lat2 burst valid pattern", 32'(vbits), 32'(5'b01110));
    check("lat2 burst data0", 32'(dat[1]), 32'hA000);
    check("lat2 burst data1", 32'(dat[2]), 32'hA001);
    check("lat2 burst data2", 32'(dat[3]), 32'hA002);

    // Reset with a read in flight, then again mid-sweep at count 7.
    drive(0, 0, 16'h0000, 2'b00, 1, 3);
    @(negedge clk);
    idle();
    sys_rst = 1'b1;
    @(negedge clk);
    check("rst discards lat2 read", 32'(valid[3:2]), 32'(0));
    sys_rst = 1'b0;
    repeat (7) @(negedge clk);
    check("busy mid sweep", 32'(busy), 32'hF);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    run_sweep("sweep after mid reset", 1'b0);
    drive(0, 0, 16'h0000, 2'b00, 1, 3);
    expect_read("cleared addr3", 16'h0000, 16'h0000);

    // Randomised traffic with frequent collisions.
    for (int n = 0; n < 800; n++) begin
      int wa;
      int ra;
      wa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
      ra = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
      drive(1'($urandom_range(0, 1)), wa, DW'($urandom()), BW'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ra);
    end
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
